// File: rtl/irq_arbiter.sv
// Edge-triggered interrupt arbiter with a single-level IDLE/REQ/SERV handshake to the CPU.
// Optional rotating priority is enabled by defining IRQ_ROUND_ROBIN_EN.
//
// state | meaning
// IDLE  | no request outstanding; waiting for an unmasked pending source
// REQ   | intr asserted; waiting for inta to latch the winner
// SERV  | CPU servicing irq_id; no nesting until eoi
module irq_arbiter #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            inta,
    input  logic            eoi,
    output logic            intr,
    output logic [IDW-1:0]  irq_id,
    output logic            busy,
    output logic [NSRC-1:0] pend,
    output logic [NSRC-1:0] mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t            state;
    logic [NSRC-1:0]   prev;
    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   cand;
    logic [NSRC-1:0]   grant_clr;
    logic [IDW-1:0]    winner;
    logic              any_cand;
    logic              grant;

    assign rise     = irq_in & ~prev;
    assign cand     = pend & ~mask;
    assign any_cand = |cand;
    assign grant    = (state == REQ) && inta && any_cand;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] idx;
    logic           found;

    // Scan starts at rr_ptr and wraps naturally through the IDW-bit index.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= winner + 1'b1;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        grant_clr = '0;
        if (grant) begin
            grant_clr[winner] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            prev <= '0;
            mask <= '1;
        end else begin
            prev <= irq_in;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // A fresh edge in the grant cycle re-pends the source (set wins over clear).
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant_clr) | rise;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state  <= IDLE;
            intr   <= 1'b0;
            busy   <= 1'b0;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_cand) begin
                        state <= REQ;
                        intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (grant) begin
                        state  <= SERV;
                        intr   <= 1'b0;
                        busy   <= 1'b1;
                        irq_id <= winner;
                    end else if (!any_cand) begin
                        state <= IDLE;
                        intr  <= 1'b0;
                    end
                end
                SERV: begin
                    if (eoi) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    intr  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: a scoreboard of expected grant ids checked on each
// rising edge of busy, plus direct status checks one step after each clock edge.
module tb_irq_arbiter;

    logic       Clk = 1'b0;
    logic       Clrn;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       inta;
    logic       eoi;
    logic       intr;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pend;
    logic [7:0] mask;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic mon_prev_busy = 1'b0;

    irq_arbiter #(.NSRC(8), .IDW(3)) dut (
        .Clk(Clk), .Clrn(Clrn), .irq_in(irq_in), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .inta(inta), .eoi(eoi), .intr(intr),
        .irq_id(irq_id), .busy(busy), .pend(pend), .mask(mask)
    );

    always #5 Clk = ~Clk;

    // Grant monitor: compares irq_id against the scoreboard whenever busy rises.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (Clrn && busy && !mon_prev_busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got irq_id=%0d, required no grant", irq_id);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(irq_id) != e) begin
                        errors++;
                        $display("FAIL grant_id: got irq_id=%0d, required %0d", irq_id, e);
                    end
                end
            end
            mon_prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic wait_intr(input string name);
        int n;
        n = 0;
        while (intr !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (intr !== 1'b1) begin
            errors++;
            $display("FAIL %s: intr timeout, got %0b, required 1", name, intr);
        end
    endtask

    task automatic ack(input int id);
        exp_q.push_back(id);
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic end_irq();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        Clrn = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; inta = 1'b0; eoi = 1'b0;
        tick();
        tick();
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_pend", pend, 8'h00);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_id", {5'd0, irq_id}, 8'h00);
        Clrn = 1'b1;
        tick();
        chk("post_rst_busy", {7'd0, busy}, 8'h00);

        // Basic handshake on source 3
        write_mask(8'h00);
        chk("mask_zero", mask, 8'h00);
        irq_in = 8'h08;
        tick();
        chk("b_pend", pend, 8'h08);
        chk("b_intr_lat0", {7'd0, intr}, 8'h00);
        tick();
        chk("b_intr_lat1", {7'd0, intr}, 8'h01);
        ack(3);
        chk("b_id", {5'd0, irq_id}, 8'h03);
        chk("b_pend_clr", pend, 8'h00);
        chk("b_busy", {7'd0, busy}, 8'h01);
        chk("b_intr_serv", {7'd0, intr}, 8'h00);
        end_irq();
        chk("b_busy_eoi", {7'd0, busy}, 8'h00);
        chk("b_intr_eoi", {7'd0, intr}, 8'h00);
        chk("b_id_hold", {5'd0, irq_id}, 8'h03);
        irq_in = 8'h00;
        tick();

        // Simultaneous sources 2 and 5
        irq_in = 8'h24;
        tick();
        chk("s_pend", pend, 8'h24);
        tick();
        chk("s_intr", {7'd0, intr}, 8'h01);
        ack(2);
        chk("s_pend_after1", pend, 8'h20);
        end_irq();
        chk("s_intr_eoi", {7'd0, intr}, 8'h00);
        tick();
        chk("s_intr_reassert", {7'd0, intr}, 8'h01);
        ack(5);
        chk("s_pend_after2", pend, 8'h00);
        end_irq();
        irq_in = 8'h00;
        tick();

        // Masking
        write_mask(8'hFF);
        irq_in = 8'h01;
        tick();
        chk("m_pend", pend, 8'h01);
        tick();
        tick();
        chk("m_intr_masked", {7'd0, intr}, 8'h00);
        write_mask(8'hFE);
        chk("m_mask", mask, 8'hFE);
        chk("m_intr_wr_edge", {7'd0, intr}, 8'h00);
        tick();
        chk("m_intr_unmasked", {7'd0, intr}, 8'h01);
        write_mask(8'hFF);
        chk("m_intr_hold", {7'd0, intr}, 8'h01);
        tick();
        chk("m_intr_drop", {7'd0, intr}, 8'h00);
        chk("m_pend_kept", pend, 8'h01);
        write_mask(8'h00);
        tick();
        chk("m_intr_again", {7'd0, intr}, 8'h01);
        ack(0);
        end_irq();
        irq_in = 8'h00;
        tick();

        // No nesting: source 1 rises while source 2 is in service
        irq_in = 8'h04;
        tick();
        tick();
        ack(2);
        irq_in = 8'h06;
        tick();
        chk("n_pend", pend, 8'h02);
        chk("n_intr0", {7'd0, intr}, 8'h00);
        tick();
        chk("n_intr1", {7'd0, intr}, 8'h00);
        end_irq();
        chk("n_intr_eoi", {7'd0, intr}, 8'h00);
        tick();
        chk("n_intr_after", {7'd0, intr}, 8'h01);
        chk("n_pend_after", pend, 8'h02);
        ack(1);
        end_irq();
        irq_in = 8'h00;
        tick();

        // Set wins: source 4 re-edges in its own grant cycle
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        chk("sw_intr", {7'd0, intr}, 8'h01);
        irq_in = 8'h10;
        ack(4);
        chk("sw_pend", pend, 8'h10);
        end_irq();
        tick();
        chk("sw_intr_again", {7'd0, intr}, 8'h01);
        ack(4);
        chk("sw_pend_clr", pend, 8'h00);
        end_irq();
        irq_in = 8'h00;
        tick();

        // Reset in SERV with source 4 pending
        irq_in = 8'h01;
        tick();
        tick();
        ack(0);
        irq_in = 8'h11;
        tick();
        chk("r_busy_pre", {7'd0, busy}, 8'h01);
        chk("r_pend_pre", pend, 8'h10);
        Clrn = 1'b0;
        tick();
        chk("r_busy", {7'd0, busy}, 8'h00);
        chk("r_intr", {7'd0, intr}, 8'h00);
        chk("r_pend", pend, 8'h00);
        chk("r_mask", mask, 8'hFF);
        chk("r_id", {5'd0, irq_id}, 8'h00);
        Clrn = 1'b1;
        irq_in = 8'h00;
        tick();
        chk("r_busy_post", {7'd0, busy}, 8'h00);

        // Sources 0 and 1 both pending on every arbitration
        write_mask(8'h00);
        irq_in = 8'h03;
        tick();
        for (int g = 0; g < 4; g++) begin
            wait_intr("rr_intr");
`ifdef IRQ_ROUND_ROBIN_EN
            ack(g % 2);
`else
            ack(0);
`endif
            irq_in = 8'h00;
            tick();
            irq_in = 8'h03;
            tick();
            end_irq();
        end
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grants_missing: got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
